// File: rtl/mat_loader.sv
// Input stage for the GF(2) matrix-vector multiplier: assembles A row by row and
// B column by column from a valid/ready word stream, then holds them until taken.
module mat_loader #(
  parameter int A_ROWS = 4,
  parameter int A_COLS = 8,
  parameter int B_COLS = 1,
  localparam int WC_W  = $clog2(A_ROWS + B_COLS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic [A_COLS-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [A_ROWS*A_COLS-1:0]   A_data_out,
  output logic [A_COLS*B_COLS-1:0]   B_data_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WC_W-1:0]            word_cnt
);

  localparam int RC_W = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;
  localparam int CC_W = (B_COLS > 1) ? $clog2(B_COLS) : 1;
  localparam logic [RC_W-1:0] LAST_ROW = RC_W'(A_ROWS - 1);
  localparam logic [CC_W-1:0] LAST_COL = CC_W'(B_COLS - 1);

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_FULL   = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [RC_W-1:0]             row_cnt_q, row_cnt_d;
  logic [CC_W-1:0]             col_cnt_q, col_cnt_d;
  logic [WC_W-1:0]             word_cnt_q, word_cnt_d;
  logic [A_ROWS*A_COLS-1:0]    a_q, a_d;
  logic [A_COLS*B_COLS-1:0]    b_q, b_d;
  logic                        accept;
  logic                        handoff;

  assign accept  = in_valid && in_ready;
  assign handoff = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clr overrides any accept or handoff in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD_A: if (accept && (row_cnt_q == LAST_ROW)) state_d = S_LOAD_B;
      S_LOAD_B: if (accept && (col_cnt_q == LAST_COL)) state_d = S_FULL;
      S_FULL:   if (handoff) state_d = S_LOAD_A;
      default:  state_d = S_LOAD_A;
    endcase
    if (clr) state_d = S_LOAD_A;
  end

  // Outputs decoded from state; in_ready is also held low while rst is asserted
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_LOAD_A: in_ready  = !rst;
      S_LOAD_B: in_ready  = !rst;
      S_FULL:   out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Counters and matrix registers; matrices survive clr and handoff
  always_comb begin
    row_cnt_d  = row_cnt_q;
    col_cnt_d  = col_cnt_q;
    word_cnt_d = word_cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    if (clr) begin
      row_cnt_d  = '0;
      col_cnt_d  = '0;
      word_cnt_d = '0;
    end else begin
      case (state_q)
        S_LOAD_A: begin
          if (accept) begin
            a_d[A_COLS*int'(row_cnt_q) +: A_COLS] = in_data;
            word_cnt_d = word_cnt_q + WC_W'(1);
            row_cnt_d  = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + RC_W'(1);
          end
        end
        S_LOAD_B: begin
          if (accept) begin
            for (int k = 0; k < A_COLS; k++) begin
              b_d[B_COLS*k + int'(col_cnt_q)] = in_data[k];
            end
            word_cnt_d = word_cnt_q + WC_W'(1);
            col_cnt_d  = (col_cnt_q == LAST_COL) ? '0 : col_cnt_q + CC_W'(1);
          end
        end
        S_FULL: begin
          if (handoff) word_cnt_d = '0;
        end
        default: begin
          row_cnt_d  = '0;
          col_cnt_d  = '0;
          word_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt_q  <= '0;
      col_cnt_q  <= '0;
      word_cnt_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      row_cnt_q  <= row_cnt_d;
      col_cnt_q  <= col_cnt_d;
      word_cnt_q <= word_cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
    end
  end

  assign A_data_out = a_q;
  assign B_data_out = b_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_mat_loader.sv
// Directed bench for mat_loader: default geometry via a vector table, plus
// hand sequences for async reset and a B_COLS=2 instance.
module tb_mat_loader;

  logic        clk;
  logic        rst, clr, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data;
  logic [31:0] a_out;
  logic [7:0]  b_out;
  logic [2:0]  wc;

  logic        rst2, clr2, in_valid2, in_ready2, out_valid2, out_ready2;
  logic [3:0]  in_data2;
  logic [7:0]  a_out2;
  logic [7:0]  b_out2;
  logic [2:0]  wc2;

  int n_total;
  int n_pass;

  mat_loader dut (
    .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .A_data_out(a_out), .B_data_out(b_out),
    .out_valid(out_valid), .out_ready(out_ready), .word_cnt(wc)
  );

  mat_loader #(.A_ROWS(2), .A_COLS(4), .B_COLS(2)) dut2 (
    .clk(clk), .rst(rst2), .clr(clr2), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .A_data_out(a_out2), .B_data_out(b_out2),
    .out_valid(out_valid2), .out_ready(out_ready2), .word_cnt(wc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       ordy;
    logic       c;
    logic [2:0] e_wc;
    logic       e_ov;
    logic       e_ir;
    logic [31:0] e_a;
    logic [7:0]  e_b;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic addv(input logic v, input logic [7:0] d, input logic ordy, input logic c,
                      input logic [2:0] wcx, input logic ov, input logic ir,
                      input logic [31:0] a, input logic [7:0] b);
    vec_t t;
    t.v = v; t.d = d; t.ordy = ordy; t.c = c;
    t.e_wc = wcx; t.e_ov = ov; t.e_ir = ir; t.e_a = a; t.e_b = b;
    vt.push_back(t);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    rst2 = 1'b1; clr2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;

    // Straight load, 10 held cycles, handoff
    addv(1, 8'h01, 0, 0, 3'd1, 0, 1, 32'h00000001, 8'h00);
    addv(1, 8'h02, 0, 0, 3'd2, 0, 1, 32'h00000201, 8'h00);
    addv(1, 8'h04, 0, 0, 3'd3, 0, 1, 32'h00040201, 8'h00);
    addv(1, 8'h08, 0, 0, 3'd4, 0, 1, 32'h08040201, 8'h00);
    addv(1, 8'hA5, 0, 0, 3'd5, 1, 0, 32'h08040201, 8'hA5);
    for (int i = 0; i < 10; i++)
      addv(1, 8'hFF, 0, 0, 3'd5, 1, 0, 32'h08040201, 8'hA5);
    addv(1, 8'h77, 1, 0, 3'd0, 0, 1, 32'h08040201, 8'hA5);
    // Reload with in_valid toggling
    addv(1, 8'h01, 0, 0, 3'd1, 0, 1, 32'h08040201, 8'hA5);
    addv(0, 8'hEE, 0, 0, 3'd1, 0, 1, 32'h08040201, 8'hA5);
    addv(1, 8'h02, 0, 0, 3'd2, 0, 1, 32'h08040201, 8'hA5);
    addv(0, 8'hEE, 0, 0, 3'd2, 0, 1, 32'h08040201, 8'hA5);
    addv(1, 8'h04, 0, 0, 3'd3, 0, 1, 32'h08040201, 8'hA5);
    addv(0, 8'hEE, 0, 0, 3'd3, 0, 1, 32'h08040201, 8'hA5);
    addv(1, 8'h08, 0, 0, 3'd4, 0, 1, 32'h08040201, 8'hA5);
    addv(0, 8'hEE, 0, 0, 3'd4, 0, 1, 32'h08040201, 8'hA5);
    addv(1, 8'hA5, 0, 0, 3'd5, 1, 0, 32'h08040201, 8'hA5);
    addv(0, 8'h00, 1, 0, 3'd0, 0, 1, 32'h08040201, 8'hA5);
    // clr after three A words with a concurrent word, then a full reload
    addv(1, 8'h11, 0, 0, 3'd1, 0, 1, 32'h08040211, 8'hA5);
    addv(1, 8'h22, 0, 0, 3'd2, 0, 1, 32'h08042211, 8'hA5);
    addv(1, 8'h33, 0, 0, 3'd3, 0, 1, 32'h08332211, 8'hA5);
    addv(1, 8'h44, 0, 1, 3'd0, 0, 1, 32'h08332211, 8'hA5);
    addv(1, 8'h55, 0, 0, 3'd1, 0, 1, 32'h08332255, 8'hA5);
    addv(1, 8'h66, 0, 0, 3'd2, 0, 1, 32'h08336655, 8'hA5);
    addv(1, 8'h77, 0, 0, 3'd3, 0, 1, 32'h08776655, 8'hA5);
    addv(1, 8'h88, 0, 0, 3'd4, 0, 1, 32'h88776655, 8'hA5);
    addv(1, 8'h3C, 0, 0, 3'd5, 1, 0, 32'h88776655, 8'h3C);
    // clr while FULL drops the load without touching the registers
    addv(0, 8'h00, 0, 1, 3'd0, 0, 1, 32'h88776655, 8'h3C);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_word_cnt", {29'b0, wc}, 32'd0);
    check("rst_A", a_out, 32'd0);
    check("rst_B", {24'b0, b_out}, 32'd0);
    rst = 1'b0;
    rst2 = 1'b0;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    foreach (vt[i]) begin
      in_valid = vt[i].v; in_data = vt[i].d; out_ready = vt[i].ordy; clr = vt[i].c;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_wc", i), {29'b0, wc}, {29'b0, vt[i].e_wc});
      check($sformatf("v%0d_ov", i), {31'b0, out_valid}, {31'b0, vt[i].e_ov});
      check($sformatf("v%0d_ir", i), {31'b0, in_ready}, {31'b0, vt[i].e_ir});
      check($sformatf("v%0d_A", i), a_out, vt[i].e_a);
      check($sformatf("v%0d_B", i), {24'b0, b_out}, {24'b0, vt[i].e_b});
    end
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;

    // Async reset mid-LOAD_B, asserted between clock edges
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h10 + 8'(i);
      @(posedge clk);
      #1;
    end
    check("preasync_wc", {29'b0, wc}, 32'd4);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_ir", {31'b0, in_ready}, 32'd0);
    check("async_wc", {29'b0, wc}, 32'd0);
    check("async_A", a_out, 32'd0);
    check("async_B", {24'b0, b_out}, 32'd0);
    check("async_ov", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A;
    #1;
    check("rel_ir", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("rel_wc", {29'b0, wc}, 32'd1);
    check("rel_A", a_out, 32'h0000005A);
    in_valid = 1'b0;

    // B_COLS=2 geometry: rows 3,C then B columns 1010, 0110
    in_valid2 = 1'b1;
    in_data2 = 4'h3;
    @(posedge clk); #1;
    check("g2_wc1", {29'b0, wc2}, 32'd1);
    in_data2 = 4'hC;
    @(posedge clk); #1;
    check("g2_A", {24'b0, a_out2}, 32'h000000C3);
    in_data2 = 4'b1010;
    @(posedge clk); #1;
    check("g2_B_col0", {24'b0, b_out2}, 32'h00000044);
    check("g2_ov_mid", {31'b0, out_valid2}, 32'd0);
    check("g2_ir_mid", {31'b0, in_ready2}, 32'd1);
    in_data2 = 4'b0110;
    @(posedge clk); #1;
    check("g2_B", {24'b0, b_out2}, {24'b0, 8'b01_10_11_00});
    check("g2_ov", {31'b0, out_valid2}, 32'd1);
    check("g2_wc4", {29'b0, wc2}, 32'd4);
    check("g2_ir_full", {31'b0, in_ready2}, 32'd0);
    in_valid2 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
